// File: rtl/mw_arith_sequencer.sv
// Multi-word add/subtract sequencer: splits a WORDS x 16-bit request into a
// least-significant-first chain of ADD/ADC ops on a shared 16-bit ALU.
module mw_arith_sequencer #(
   parameter int WORDS = 4
) (
   input  logic                  iClock,
   input  logic                  iReset,
   input  logic                  iReqValid,
   output logic                  oReqReady,
   input  logic                  iReqOp,
   input  logic [16*WORDS-1:0]   iReqA,
   input  logic [16*WORDS-1:0]   iReqB,
   output logic                  oRspValid,
   input  logic                  iRspReady,
   output logic [16*WORDS-1:0]   oRspResult,
   output logic                  oRspCarry,
   output logic                  oRspZero,
   output logic [15:0]           oPortA,
   output logic [15:0]           oPortB,
   output logic [1:0]            oOpcode,
   input  logic [15:0]           iAccumulator,
   input  logic                  iCarryflag
);

   // state | meaning
   // IDLE  | waiting for a request; ALU driven with ADD 0+0
   // PRIME | subtract only: ADD FFFF+0001 forces the ALU carry to 1
   // RUN   | one ALU op per word, word index k_q = 0..WORDS-1
   // CAPT  | sample the final carry and the zero accumulator
   // RESP  | hold the response until iRspReady
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRIME = 3'd1,
      RUN   = 3'd2,
      CAPT  = 3'd3,
      RESP  = 3'd4
   } state_t;

   localparam int              W      = 16 * WORDS;
   localparam int              KW     = $clog2(WORDS);
   localparam logic [KW-1:0]   K_LAST = KW'(WORDS - 1);
   localparam logic [1:0]      OP_ADD = 2'b01;
   localparam logic [1:0]      OP_ADC = 2'b10;

   state_t          state_q,    state_d;
   logic [KW-1:0]   k_q,        k_d;
   logic [W-1:0]    a_q,        a_d;
   logic [W-1:0]    b_q,        b_d;
   logic            zero_q,     zero_d;
   logic [W-1:0]    result_q,   result_d;
   logic            carry_q,    carry_d;
   logic            rsp_zero_q, rsp_zero_d;
   logic            valid_q,    valid_d;
   logic [15:0]     port_a_q,   port_a_d;
   logic [15:0]     port_b_q,   port_b_d;
   logic [1:0]      opcode_q,   opcode_d;
   logic [KW-1:0]   k_nxt;

   assign k_nxt = k_q + 1'b1;

   // ALU drive is registered, so each branch sets up the operands for the
   // cycle that follows the transition it takes.
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      a_d        = a_q;
      b_d        = b_q;
      zero_d     = zero_q;
      result_d   = result_q;
      carry_d    = carry_q;
      rsp_zero_d = rsp_zero_q;
      valid_d    = valid_q;
      port_a_d   = port_a_q;
      port_b_d   = port_b_q;
      opcode_d   = opcode_q;

      case (state_q)
         IDLE: begin
            if (iReqValid) begin
               a_d    = iReqA;
               b_d    = iReqOp ? ~iReqB : iReqB;
               zero_d = 1'b1;
               k_d    = '0;
               opcode_d = OP_ADD;
               if (iReqOp) begin
                  state_d  = PRIME;
                  port_a_d = 16'hFFFF;
                  port_b_d = 16'h0001;
               end else begin
                  state_d  = RUN;
                  port_a_d = iReqA[15:0];
                  port_b_d = iReqB[15:0];
               end
            end
         end
         PRIME: begin
            state_d  = RUN;
            k_d      = '0;
            port_a_d = a_q[15:0];
            port_b_d = b_q[15:0];
            opcode_d = OP_ADC;
         end
         RUN: begin
            result_d[{k_q, 4'b0000} +: 16] = iAccumulator;
            if (iAccumulator != 16'h0000) begin
               zero_d = 1'b0;
            end
            if (k_q == K_LAST) begin
               state_d  = CAPT;
               port_a_d = 16'h0000;
               port_b_d = 16'h0000;
               opcode_d = OP_ADD;
            end else begin
               k_d      = k_nxt;
               port_a_d = a_q[{k_nxt, 4'b0000} +: 16];
               port_b_d = b_q[{k_nxt, 4'b0000} +: 16];
               opcode_d = OP_ADC;
            end
         end
         CAPT: begin
            carry_d    = iCarryflag;
            rsp_zero_d = zero_q;
            valid_d    = 1'b1;
            state_d    = RESP;
         end
         RESP: begin
            if (iRspReady) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            port_a_d = 16'h0000;
            port_b_d = 16'h0000;
            opcode_d = OP_ADD;
         end
      endcase
   end

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         state_q    <= IDLE;
         k_q        <= '0;
         a_q        <= '0;
         b_q        <= '0;
         zero_q     <= 1'b0;
         result_q   <= '0;
         carry_q    <= 1'b0;
         rsp_zero_q <= 1'b0;
         valid_q    <= 1'b0;
         port_a_q   <= 16'h0000;
         port_b_q   <= 16'h0000;
         opcode_q   <= OP_ADD;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         a_q        <= a_d;
         b_q        <= b_d;
         zero_q     <= zero_d;
         result_q   <= result_d;
         carry_q    <= carry_d;
         rsp_zero_q <= rsp_zero_d;
         valid_q    <= valid_d;
         port_a_q   <= port_a_d;
         port_b_q   <= port_b_d;
         opcode_q   <= opcode_d;
      end
   end

   assign oReqReady  = (state_q == IDLE);
   assign oRspValid  = valid_q;
   assign oRspResult = result_q;
   assign oRspCarry  = carry_q;
   assign oRspZero   = rsp_zero_q;
   assign oPortA     = port_a_q;
   assign oPortB     = port_b_q;
   assign oOpcode    = opcode_q;

endmodule

// File: tb/tb_mw_arith_sequencer.sv
// Bench for mw_arith_sequencer: behavioural 16-bit ALU plus a whole-word
// arithmetic reference model; directed cases followed by random requests.
module tb_mw_arith_sequencer;

   localparam int WORDS = 4;
   localparam int W     = 16 * WORDS;

   logic           iClock = 1'b0;
   logic           iReset;
   logic           iReqValid;
   logic           oReqReady;
   logic           iReqOp;
   logic [W-1:0]   iReqA;
   logic [W-1:0]   iReqB;
   logic           oRspValid;
   logic           iRspReady;
   logic [W-1:0]   oRspResult;
   logic           oRspCarry;
   logic           oRspZero;
   logic [15:0]    oPortA;
   logic [15:0]    oPortB;
   logic [1:0]     oOpcode;
   logic [15:0]    iAccumulator;
   logic           iCarryflag;

   int checks   = 0;
   int failures = 0;

   mw_arith_sequencer #(.WORDS(WORDS)) dut (
      .iClock       (iClock),
      .iReset       (iReset),
      .iReqValid    (iReqValid),
      .oReqReady    (oReqReady),
      .iReqOp       (iReqOp),
      .iReqA        (iReqA),
      .iReqB        (iReqB),
      .oRspValid    (oRspValid),
      .iRspReady    (iRspReady),
      .oRspResult   (oRspResult),
      .oRspCarry    (oRspCarry),
      .oRspZero     (oRspZero),
      .oPortA       (oPortA),
      .oPortB       (oPortB),
      .oOpcode      (oOpcode),
      .iAccumulator (iAccumulator),
      .iCarryflag   (iCarryflag)
   );

   always #5 iClock = ~iClock;

   // ALU: combinational result, carry flag registered each edge, never reset
   logic [16:0] alu_sum;
   logic        alu_cf = 1'b0;
   always_comb begin
      case (oOpcode)
         2'b01:   alu_sum = {1'b0, oPortA} + {1'b0, oPortB};
         2'b10:   alu_sum = {1'b0, oPortA} + {1'b0, oPortB} + {16'h0, alu_cf};
         2'b11:   alu_sum = {1'b0, oPortA} + {1'b0, ~oPortB} + 17'h1;
         default: alu_sum = 17'h0;
      endcase
   end
   always @(posedge iClock) alu_cf <= alu_sum[16];
   assign iAccumulator = alu_sum[15:0];
   assign iCarryflag   = alu_cf;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic void ref_model(input bit op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] r, output logic c, output logic z);
      if (!op) begin
         {c, r} = {1'b0, a} + {1'b0, b};
      end else begin
         r = a - b;
         c = (a >= b);
      end
      z = (r == '0);
   endfunction

   task automatic run_txn(input bit op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
      logic [W-1:0] exp_r;
      logic [W-1:0] bx;
      logic         exp_c;
      logic         exp_z;
      logic [33:0]  exp_drv;
      int           c;
      int           p;
      int           j;
      ref_model(op, a, b, exp_r, exp_c, exp_z);
      bx = op ? ~b : b;
      p  = op ? 1 : 0;
      check("req_ready_idle", oReqReady, 1'b1);
      iReqValid = 1'b1;
      iReqOp    = op;
      iReqA     = a;
      iReqB     = b;
      @(posedge iClock);
      @(negedge iClock);
      iReqValid = 1'b0;
      iReqA     = {$urandom, $urandom};
      iReqB     = {$urandom, $urandom};
      iReqOp    = 1'($urandom);
      c = 0;
      while (!oRspValid && c < 20) begin
         if (op && c == 0) begin
            exp_drv = {2'b01, 16'hFFFF, 16'h0001};
         end else if (c < WORDS + p) begin
            j = c - p;
            exp_drv = {(j == 0 && !op) ? 2'b01 : 2'b10, a[j*16 +: 16], bx[j*16 +: 16]};
         end else begin
            exp_drv = {2'b01, 32'h0};
         end
         check("alu_drive", {oOpcode, oPortA, oPortB}, exp_drv);
         check("req_ready_busy", oReqReady, 1'b0);
         @(negedge iClock);
         c++;
      end
      check("latency", c, WORDS + 1 + p);
      for (int h = 0; h < hold; h++) begin
         check("rsp_hold", {oRspValid, oReqReady, oRspCarry, oRspZero, oRspResult},
               {1'b1, 1'b0, exp_c, exp_z, exp_r});
         @(negedge iClock);
      end
      check("result", oRspResult, exp_r);
      check("carry", oRspCarry, exp_c);
      check("zero", oRspZero, exp_z);
      iRspReady = 1'b1;
      @(negedge iClock);
      iRspReady = 1'b0;
      check("rsp_done", {oRspValid, oReqReady}, 2'b01);
   endtask

   logic [W-1:0] ra;
   logic [W-1:0] rb;
   bit           rop;

   initial begin
      iReset    = 1'b1;
      iReqValid = 1'b0;
      iReqOp    = 1'b0;
      iReqA     = '0;
      iReqB     = '0;
      iRspReady = 1'b0;
      repeat (3) @(negedge iClock);
      check("reset_outputs", {oReqReady, oRspValid, oRspCarry, oRspZero, oRspResult, oPortA, oPortB, oOpcode},
            {1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 16'h0, 16'h0, 2'b01});
      iReset = 1'b0;
      @(negedge iClock);

      run_txn(1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 0);
      run_txn(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0);
      run_txn(1'b1, 64'h0001_0000_0000_0000, 64'h1, 0);
      run_txn(1'b1, 64'h5, 64'h7, 1);
      run_txn(1'b1, 64'h1234, 64'h1234, 0);
      run_txn(1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3);
      run_txn(1'b1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 2);

      // Reset during RUN word 2, with a request presented while reset is high
      iReqValid = 1'b1;
      iReqOp    = 1'b0;
      iReqA     = 64'h1111_2222_3333_4444;
      iReqB     = 64'h5555_6666_7777_8888;
      @(posedge iClock);
      repeat (3) @(negedge iClock);
      iReset = 1'b1;
      #1;
      check("abort_outputs", {oReqReady, oRspValid, oRspCarry, oRspZero, oRspResult, oPortA, oPortB, oOpcode},
            {1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 16'h0, 16'h0, 2'b01});
      repeat (2) @(negedge iClock);
      iReset    = 1'b0;
      iReqValid = 1'b0;
      @(negedge iClock);
      check("reset_wins", {oReqReady, oRspValid, oPortA, oPortB, oOpcode},
            {1'b1, 1'b0, 16'h0, 16'h0, 2'b01});
      run_txn(1'b0, 64'h1, 64'h1, 0);

      for (int i = 0; i < 40; i++) begin
         rop = 1'($urandom);
         ra  = {$urandom, $urandom};
         case ($urandom_range(0, 4))
            0:       rb = ra;
            1:       rb = '1;
            2:       rb = ra + 64'h1;
            default: rb = {$urandom, $urandom};
         endcase
         run_txn(rop, ra, rb, $urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mw_arith_sequencer.md
Name: mw_arith_sequencer

Overview:
- Multi-word add/subtract initiator that drives the 16-bit arithmetic unit's operand, opcode and result/flag interface.
- Splits a WORDS×16-bit request into a chain of 16-bit ADD/ADC operations, least-significant word first.
- Collects each accumulator word and returns the full result with carry and zero flags over a valid/ready response port.
- Sits between the datapath controller (request side) and the arithmetic unit (ALU side).

Parameters:
- WORDS, 4, number of 16-bit words per operand; legal range 2..8. Operand width W = 16*WORDS.

Ports:
- iClock  in  1  system clock; all state updates on the rising edge.
- iReset  in  1  asynchronous, active-high reset.
- iReqValid  in  1  request valid.
- oReqReady  out  1  request ready; high only in IDLE.
- iReqOp  in  1  0 = add, 1 = subtract (A − B).
- iReqA  in  W  operand A.
- iReqB  in  W  operand B.
- oRspValid  out  1  response valid.
- iRspReady  in  1  response accepted.
- oRspResult  out  W  result.
- oRspCarry  out  1  final carry; for subtract, 1 = no borrow.
- oRspZero  out  1  1 when oRspResult == 0.
- oPortA  out  16  ALU operand A.
- oPortB  out  16  ALU operand B.
- oOpcode  out  2  ALU opcode: 01 ADD, 10 ADC, 11 SUB (never issued).
- iAccumulator  in  16  ALU result; combinational in the same cycle.
- iCarryflag  in  1  ALU registered carry flag; updated at each clock edge from the op issued that cycle.

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE; word index = 0.
  - oRspValid = 0, oRspResult = 0, oRspCarry = 0, oRspZero = 0.
  - oPortA = 0, oPortB = 0, oOpcode = 01.
- oReqReady = 1 exactly when the state is IDLE.
- Idle drive: in IDLE, CAPT and RESP the block drives oOpcode = 01 and oPortA = oPortB = 0. This clears the ALU carry flag; the block never depends on it.
- IDLE: when iReqValid && oReqReady, latch A, latch B (inverted when iReqOp = 1) and latch op; clear the zero accumulator.
  - Next state is PRIME for subtract, RUN with k = 0 for add.
- PRIME (subtract only, 1 cycle):
  - Drive ADD with A = 16'hFFFF, B = 16'h0001, so the ALU carry flag becomes 1.
  - Accumulator output is ignored. Next state: RUN, k = 0.
- RUN (WORDS cycles, k = 0..WORDS−1):
  - Drive oPortA = A word k and oPortB = latched B word k.
  - oOpcode = ADD when k = 0 and the op is add; ADC otherwise, i.e. every subtract word and add words k ≥ 1.
  - At the edge, write iAccumulator into result word k.
  - Clear the zero accumulator if iAccumulator ≠ 0.
  - After k = WORDS−1, go to CAPT.
- CAPT (1 cycle):
  - oRspCarry <= iCarryflag, which is the carry of the last ADC.
  - oRspZero <= zero accumulator.
  - oRspValid <= 1. Next state: RESP.
- RESP:
  - Hold oRspValid, oRspResult, oRspCarry and oRspZero stable until iRspReady = 1.
  - On the handshake edge, oRspValid <= 0 and the state returns to IDLE. The next request can be accepted one cycle later.
- Latency, from the accept edge to the first cycle with oRspValid = 1:
  - Add: WORDS+1 cycles.
  - Subtract: WORDS+2 cycles.
- Arithmetic:
  - Add: result = (A + B) mod 2^W; carry = bit W of the sum.
  - Subtract: result = (A + ~B + 1) mod 2^W; carry = 1 when A ≥ B (unsigned).
- Boundary cases:
  - iReqValid while busy: ignored; the request must be held by the requester.
  - iReqValid together with iReset: reset wins and the request is not accepted.
  - Reset in PRIME, RUN, CAPT or RESP: abort immediately to IDLE with all reset values; the partial result is discarded.
  - The next request is correct regardless of ALU carry state, because it starts with ADD or PRIME.
  - Operands are latched on accept; changes to iReqA/iReqB after accept have no effect.

Test Plan (WORDS = 4):
1. Add 0x0000_0000_FFFF_FFFF + 0x1 -> opcodes 01,10,10,10; result 0x0000_0001_0000_0000, carry 0, zero 0; oRspValid 5 cycles after accept.
2. Add 0xFFFF_FFFF_FFFF_FFFF + 0x1 -> result 0, carry 1, zero 1.
3. Sub 0x0001_0000_0000_0000 − 0x1 -> prime (01, FFFF/0001), then 10×4 with oPortB words FFFE,FFFF,FFFF,FFFF; result 0x0000_FFFF_FFFF_FFFF, carry 1; latency 6.
4. Sub 0x5 − 0x7 -> result 0xFFFF_FFFF_FFFF_FFFE, carry 0, zero 0. Sub 0x1234 − 0x1234 -> result 0, carry 1, zero 1.
5. Hold iRspReady low 3 cycles in RESP -> response outputs stable, oReqReady 0; a back-to-back request is accepted the cycle after the handshake and returns the correct result.
6. Assert iReset during RUN word 2 -> all outputs at reset values immediately, state IDLE; a following add of 0x1 + 0x1 returns 0x2, carry 0.
